// File: rtl/led_controller_pkg.sv
// Shared register map and bus lane constants for the multi-channel LED controller.
package led_controller_pkg;

  localparam logic [3:0] REG_LED_ON      = 4'd0;
  localparam logic [3:0] REG_BLINK_EN    = 4'd1;
  localparam logic [3:0] REG_BLINK_HALF  = 4'd2;
  localparam logic [3:0] REG_BRIGHT_BASE = 4'd8;

  // Byte 0 of the bus word lives in the top byte of data_in.
  localparam int unsigned LANE0_LSB = 24;

endpackage

// File: rtl/led_pwm_channel.sv
// One LED channel: brightness register, PWM duty compare, on/blink gating, output flop.
module led_pwm_channel #(
  parameter int unsigned PWM_BITS = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                bright_we,
  input  logic [PWM_BITS-1:0] bright_wdata,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                on,
  input  logic                blink_en,
  input  logic                blink_phase,
  output logic [PWM_BITS-1:0] bright,
  output logic                led
);

  logic [PWM_BITS-1:0] bright_q;
  logic                led_q;
  logic                pwm_on;
  logic                led_d;

  always_comb begin
    // All-ones must be solidly on, which the plain compare alone cannot give.
    pwm_on = (&bright_q) || (pwm_cnt < bright_q);
    led_d  = on && pwm_on && (!blink_en || !blink_phase);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      bright_q <= '1;
      led_q    <= 1'b0;
    end else begin
      if (bright_we) begin
        bright_q <= bright_wdata;
      end
      led_q <= led_d;
    end
  end

  assign bright = bright_q;
  assign led    = led_q;

endmodule

// File: rtl/led_controller.sv
// Multi-channel LED controller: bus decode, shared PWM counter, blink divider and read mux.
module led_controller
  import led_controller_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 4,
  parameter int unsigned PWM_BITS       = 8,
  parameter int unsigned BLINK_DIV_BITS = 24,
  parameter logic [23:0] BLINK_RESET    = 24'd8_000_000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                cs,
  input  logic                write,
  input  logic [3:0]          address,
  input  logic [31:0]         data_in,
  output logic [31:0]         data_out,
  output logic [NUM_LEDS-1:0] led
);

  logic [NUM_LEDS-1:0]       on_q, on_d;
  logic [NUM_LEDS-1:0]       blink_en_q, blink_en_d;
  logic [BLINK_DIV_BITS-1:0] half_q, half_d;
  logic [BLINK_DIV_BITS-1:0] div_q, div_d;
  logic                      blink_phase_q, blink_phase_d;
  logic [PWM_BITS-1:0]       pwm_cnt_q, pwm_cnt_d;
  logic [31:0]               data_out_q, data_out_d;

  logic [BLINK_DIV_BITS-1:0] half_eff;
  logic                      wrap;
  logic                      wr_en;
  logic [31:0]               rdata;
  logic [PWM_BITS-1:0]       bright [NUM_LEDS];

  logic unused_data;
  assign unused_data = ^data_in;

  assign wr_en = cs && write;

  always_comb begin
    on_d       = on_q;
    blink_en_d = blink_en_q;
    half_d     = half_q;
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);

    // A half-period of 0 would never wrap; treat it as 1.
    half_eff      = (half_q == '0) ? BLINK_DIV_BITS'(1) : half_q;
    wrap          = (div_q == half_eff - BLINK_DIV_BITS'(1));
    div_d         = wrap ? '0 : div_q + BLINK_DIV_BITS'(1);
    blink_phase_d = blink_phase_q ^ wrap;

    if (wr_en) begin
      unique case (address)
        REG_LED_ON:   on_d       = data_in[LANE0_LSB +: NUM_LEDS];
        REG_BLINK_EN: blink_en_d = data_in[LANE0_LSB +: NUM_LEDS];
        REG_BLINK_HALF: begin
          // Restart the blink cycle cleanly; overrides a coincident wrap.
          half_d        = data_in[BLINK_DIV_BITS-1:0];
          div_d         = '0;
          blink_phase_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    unique case (address)
      REG_LED_ON:     rdata[LANE0_LSB +: NUM_LEDS] = on_q;
      REG_BLINK_EN:   rdata[LANE0_LSB +: NUM_LEDS] = blink_en_q;
      REG_BLINK_HALF: rdata[BLINK_DIV_BITS-1:0]    = half_q;
      default: begin
        for (int unsigned i = 0; i < NUM_LEDS; i++) begin
          if (address == REG_BRIGHT_BASE + 4'(i)) begin
            rdata[PWM_BITS-1:0] = bright[i];
          end
        end
      end
    endcase
    data_out_d = (cs && !write) ? rdata : data_out_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      on_q          <= '0;
      blink_en_q    <= '0;
      half_q        <= BLINK_RESET[BLINK_DIV_BITS-1:0];
      div_q         <= '0;
      blink_phase_q <= 1'b0;
      pwm_cnt_q     <= '0;
      data_out_q    <= '0;
    end else begin
      on_q          <= on_d;
      blink_en_q    <= blink_en_d;
      half_q        <= half_d;
      div_q         <= div_d;
      blink_phase_q <= blink_phase_d;
      pwm_cnt_q     <= pwm_cnt_d;
      data_out_q    <= data_out_d;
    end
  end

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    led_pwm_channel #(
      .PWM_BITS(PWM_BITS)
    ) u_chan (
      .clock       (clock),
      .reset       (reset),
      .bright_we   (wr_en && (address == REG_BRIGHT_BASE + 4'(i))),
      .bright_wdata(data_in[PWM_BITS-1:0]),
      .pwm_cnt     (pwm_cnt_q),
      .on          (on_q[i]),
      .blink_en    (blink_en_q[i]),
      .blink_phase (blink_phase_q),
      .bright      (bright[i]),
      .led         (led[i])
    );
  end

  assign data_out = data_out_q;

endmodule

// File: tb/tb_led_controller.sv
// Scoreboard bench for led_controller: stimulus queues expectations, a negedge monitor checks.
module tb_led_controller;

  localparam int NL   = 4;
  localparam int HIST = 4096;
  localparam int K_DOUT = 0;
  localparam int K_LED  = 1;
  localparam int K_CNT  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          cs = 1'b0;
  logic          write = 1'b0;
  logic [3:0]    address = 4'd0;
  logic [31:0]   data_in = 32'd0;
  logic [31:0]   data_out;
  logic [NL-1:0] led;

  led_controller #(
    .NUM_LEDS      (NL),
    .PWM_BITS      (8),
    .BLINK_DIV_BITS(24),
    .BLINK_RESET   (24'd8_000_000)
  ) u_dut (
    .clock   (clock),
    .reset   (reset),
    .cs      (cs),
    .write   (write),
    .address (address),
    .data_in (data_in),
    .data_out(data_out),
    .led     (led)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    string       name;
    int          cyc;
    int          kind;
    int          bit_idx;
    int          len;
    logic [31:0] exp;
  } chk_t;

  chk_t sb_q[$];
  bit   done = 1'b0;

  task automatic push(input string nm, input int c, input int k, input int b, input int l,
                      input logic [31:0] e);
    chk_t t;
    t.name = nm; t.cyc = c; t.kind = k; t.bit_idx = b; t.len = l; t.exp = e;
    sb_q.push_back(t);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    cs = 1'b1; write = 1'b1; address = a; data_in = d;
    @(posedge clock);
    #1;
    cs = 1'b0; write = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic [31:0] e, input string nm);
    cs = 1'b1; write = 1'b0; address = a;
    @(posedge clock);
    #1;
    cs = 1'b0;
    push(nm, cyc, K_DOUT, 0, 0, e);
  endtask

  // Monitor / scoreboard
  logic [NL-1:0] hist [HIST];
  int   checks = 0;
  int   errors = 0;
  int   drain = 0;
  int   n;
  logic [31:0] act;
  chk_t it;

  always @(negedge clock) begin
    hist[cyc % HIST] = led;
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      it = sb_q.pop_front();
      checks++;
      if (it.cyc < cyc) begin
        errors++;
        $display("FAIL %s: sample cycle %0d missed, now at %0d", it.name, it.cyc, cyc);
      end else begin
        if (it.kind == K_DOUT) begin
          act = data_out;
        end else if (it.kind == K_LED) begin
          act = 32'(led);
        end else begin
          n = 0;
          for (int j = 0; j < it.len; j++) n += int'(hist[(it.cyc - j) % HIST][it.bit_idx]);
          act = 32'(n);
        end
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s @cyc %0d: got %0h want %0h", it.name, cyc, act, it.exp);
        end
      end
    end
    if (done) begin
      drain++;
      if (sb_q.size() == 0 || drain > 2000) begin
        if (sb_q.size() != 0) begin
          errors++;
          $display("FAIL drain: %0d checks pending, want 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    end
  end

  // Stimulus
  logic [31:0] pwm_wr  [5] = '{32'h40, 32'h00, 32'hFF, 32'h01, 32'hFFFF_FFFE};
  int          pwm_cnt [5] = '{64, 0, 256, 1, 254};

  initial begin
    int w;
    repeat (3) @(posedge clock);
    #1;
    push("rst_dout", cyc, K_DOUT, 0, 0, 32'h0);
    push("rst_led", cyc, K_LED, 0, 0, 32'h0);
    reset = 1'b1;

    bus_read(4'd0, 32'h0, "rst_led_on");
    bus_read(4'd1, 32'h0, "rst_blink_en");
    bus_read(4'd2, 32'h007A_1200, "rst_half");
    bus_read(4'd8, 32'hFF, "rst_bright0");
    bus_read(4'd11, 32'hFF, "rst_bright3");

    // Unmapped addresses, including BRIGHT slots beyond NUM_LEDS
    bus_write(4'd3, 32'hFFFF_FFFF);
    bus_write(4'd15, 32'hFFFF_FFFF);
    bus_write(4'd12, 32'hFFFF_FFFF);
    bus_read(4'd0, 32'h0, "unmap_led_on");
    bus_read(4'd1, 32'h0, "unmap_blink_en");
    bus_read(4'd2, 32'h007A_1200, "unmap_half");
    bus_read(4'd11, 32'hFF, "unmap_bright3");
    bus_read(4'd3, 32'h0, "rd_addr3");
    bus_read(4'd15, 32'h0, "rd_addr15");
    bus_read(4'd12, 32'h0, "rd_addr12");
    push("unmap_led", cyc, K_LED, 0, 0, 32'h0);

    // Single channel on at full brightness
    bus_write(4'd0, 32'h0100_0000);
    w = cyc;
    for (int k = 1; k <= 5; k++) push("led0_on", w + k, K_LED, 0, 0, 32'h1);
    idle(5);
    bus_read(4'd0, 32'h0100_0000, "rd_led_on");

    // PWM duty on channel 1
    bus_write(4'd9, pwm_wr[0]);
    bus_write(4'd0, 32'h0200_0000);
    w = cyc;
    push("pwm_40", w + 256, K_CNT, 1, 256, 32'(pwm_cnt[0]));
    idle(256);
    for (int p = 1; p < 5; p++) begin
      bus_write(4'd9, pwm_wr[p]);
      w = cyc;
      push("pwm_duty", w + 256, K_CNT, 1, 256, 32'(pwm_cnt[p]));
      idle(256);
    end
    bus_read(4'd9, 32'hFE, "rd_bright1");

    // Blink with half-period 10 on channels 0 and 1
    bus_write(4'd9, 32'hFF);
    bus_write(4'd1, 32'h0300_0000);
    bus_write(4'd0, 32'h0300_0000);
    bus_write(4'd2, 32'd10);
    w = cyc;
    for (int k = 1; k <= 40; k++)
      push("blink10", w + k, K_LED, 0, 0, (((k - 1) / 10) % 2 == 0) ? 32'h3 : 32'h0);
    idle(40);

    // Half-period 0 behaves as 1
    bus_write(4'd2, 32'd0);
    w = cyc;
    for (int k = 1; k <= 8; k++)
      push("blink0", w + k, K_LED, 0, 0, (k % 2 == 1) ? 32'h3 : 32'h0);
    idle(8);

    // BLINK_HALF write on the wrap edge clears the phase
    bus_write(4'd2, 32'd10);
    idle(9);
    bus_write(4'd2, 32'd4);
    w = cyc;
    for (int k = 1; k <= 12; k++)
      push("wrap_write", w + k, K_LED, 0, 0, (((k - 1) / 4) % 2 == 0) ? 32'h3 : 32'h0);
    idle(12);
    bus_read(4'd2, 32'd4, "rd_half4");

    // Reset mid-blink
    bus_write(4'd0, 32'hFF00_0000);
    bus_read(4'd0, 32'h0F00_0000, "rd_led_on_all");
    reset = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    push("midrst_dout", cyc, K_DOUT, 0, 0, 32'h0);
    push("midrst_led", cyc, K_LED, 0, 0, 32'h0);
    bus_read(4'd0, 32'h0, "midrst_led_on");
    bus_read(4'd1, 32'h0, "midrst_blink_en");
    bus_read(4'd2, 32'h007A_1200, "midrst_half");
    bus_read(4'd9, 32'hFF, "midrst_bright1");
    push("midrst_led_after", cyc, K_LED, 0, 0, 32'h0);
    idle(2);
    done = 1'b1;
  end

endmodule

// File: doc/led_controller.md
# led_controller

Parametrised multi-channel LED controller on the CPU register bus, generalising the single on/off LED bit to up to 8 channels. Each channel has an on/off bit, 8-bit PWM brightness and an optional shared-rate blink. The block sits behind the bus chip-select decoder like the other simple peripherals. It drives board LED pins directly from registered outputs.

## Interface
Parameters:
- NUM_LEDS, 4, number of channels, legal 1..8
- PWM_BITS, 8, brightness and PWM counter width, legal 1..8
- BLINK_DIV_BITS, 24, width of the blink half-period register, legal 1..24
- BLINK_RESET, 24'd8_000_000, reset half-period in clocks

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-low
- cs  in  1  chip select from decoder
- write  in  1  1 = write cycle, 0 = read cycle
- address  in  4  longword register index
- data_in  in  32  write data; byte 0 is data_in[31:24]
- data_out  out  32  registered read data
- led  out  NUM_LEDS  LED drive, active-high

## Operation
Register map. Unused bits write-ignored and read 0.
- 0 LED_ON: data_in[24+i] = channel i enable. Bit 24 is channel 0.
- 1 BLINK_EN: data_in[24+i] = channel i blinks.
- 2 BLINK_HALF: data_in[BLINK_DIV_BITS-1:0] = half-period in clocks. Value 0 behaves as 1.
- 8+i BRIGHT_i, for i < NUM_LEDS: data_in[PWM_BITS-1:0] = duty.
- Any other address: writes ignored, reads return 0. This includes 8+i for i ≥ NUM_LEDS.

Writes take effect when cs && write is sampled high on a clock edge. Reads load data_out when cs && !write is sampled. data_out holds its value otherwise.

PWM:
- pwm_cnt is a free-running PWM_BITS counter that wraps.
- pwm_on[i] = (bright[i] == all-ones) || (pwm_cnt < bright[i]).
- Duty 0 is always off; all-ones is always on.

Blink:
- A single divider counts 0..half-1, then wraps and toggles blink_phase.
- Phase 0 is the visible half.
- A BLINK_HALF write loads the new half-period, clears the divider and clears blink_phase.
- That write wins over a coincident wrap.

Output:
- led[i] <= on[i] && pwm_on[i] && (!blink_en[i] || !blink_phase).

## Timing
Reset values (reset low at an edge):
- on = 0, blink_en = 0, half = BLINK_RESET
- bright[*] = all-ones, so enabling a channel alone gives full brightness (the legacy single-LED behaviour)
- pwm_cnt = 0, divider = 0, blink_phase = 0
- led = 0, data_out = 0

Latency:
- Register write to led change: 1 clock after the write edge, plus any wait for the PWM/blink condition.
- Read: data_out is valid the clock after cs && !write is sampled.

Mid-operation behaviour:
- Reset asserted mid-blink or mid-PWM restores all reset values on that edge.
- Brightness changes apply from the next pwm_cnt compare. There is no period resynchronisation and glitch-length pulses are acceptable.

## Structure
- Package led_controller_pkg holds:
  - register index constants: REG_LED_ON = 0, REG_BLINK_EN = 1, REG_BLINK_HALF = 2, REG_BRIGHT_BASE = 8
  - byte-lane constant LANE0_LSB = 24
- Sub-module led_pwm_channel, instantiated NUM_LEDS times via generate. It contains:
  - the bright register with its write enable
  - the duty compare
  - the on/blink gating
  - the led output flop
- The top level holds the bus decode, the shared pwm_cnt, the blink divider and the read mux.

## Test plan
- Reset low then high, write LED_ON = 0x01000000 -> led[0] = 1 continuously from the next clock, others 0; read address 0 returns 0x01000000.
- BRIGHT_1 = 0x40, LED_ON bit 25 set -> led[1] high exactly 64 of every 256 clocks. BRIGHT_1 = 0 -> never high; 0xFF -> always high.
- BLINK_HALF = 10, BLINK_EN = LED_ON = 0x03000000 -> led[1:0] high for 10 clocks, low for 10, repeating. BLINK_HALF = 0 -> toggles every clock.
- Write BLINK_HALF on the same edge the divider wraps -> phase cleared, not toggled; next toggle after the new half-period.
- Write address 15 with NUM_LEDS = 4 and address 3 -> no state change; reads of both return 0.
- Assert reset mid-blink with LED_ON = 0xFF000000 -> led = 0 and all registers at reset values on the next edge.
